// File: rtl/vga_pkg.sv
// Shared timing defaults and pipeline types for the VGA frame fetch path.
package vga_pkg;

   localparam int H_ACTIVE_DFLT    = 640;
   localparam int H_FP_DFLT        = 16;
   localparam int H_SYNC_DFLT      = 96;
   localparam int H_BP_DFLT        = 48;
   localparam int V_ACTIVE_DFLT    = 480;
   localparam int V_FP_DFLT        = 10;
   localparam int V_SYNC_DFLT      = 2;
   localparam int V_BP_DFLT        = 33;
   localparam int H_TOTAL_DFLT     = H_ACTIVE_DFLT + H_FP_DFLT + H_SYNC_DFLT + H_BP_DFLT;
   localparam int V_TOTAL_DFLT     = V_ACTIVE_DFLT + V_FP_DFLT + V_SYNC_DFLT + V_BP_DFLT;
   localparam int SCALE_SHIFT_DFLT = 4;
   localparam int CELLS_X_DFLT     = H_ACTIVE_DFLT >> SCALE_SHIFT_DFLT;
   localparam int CELLS_Y_DFLT     = V_ACTIVE_DFLT >> SCALE_SHIFT_DFLT;
   localparam int NUM_CELLS_DFLT   = CELLS_X_DFLT * CELLS_Y_DFLT;
   localparam int PIX_W            = 8;
   localparam int ADDR_W_DFLT      = 11;

   // Per-pixel video control travelling alongside the RAM read; syncs are active-low.
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
   } vid_ctl_t;

   localparam vid_ctl_t CTL_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/vga_timing_gen.sv
// Stage-0 raster counters with raw active and active-low sync flags.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DFLT,
   parameter int H_FP     = H_FP_DFLT,
   parameter int H_SYNC   = H_SYNC_DFLT,
   parameter int H_BP     = H_BP_DFLT,
   parameter int V_ACTIVE = V_ACTIVE_DFLT,
   parameter int V_FP     = V_FP_DFLT,
   parameter int V_SYNC   = V_SYNC_DFLT,
   parameter int V_BP     = V_BP_DFLT,
   parameter int HCNT_W   = 10,
   parameter int VCNT_W   = 10
) (
   input  logic              clk,
   input  logic              reset,
   output logic [HCNT_W-1:0] hcount_o,
   output logic [VCNT_W-1:0] vcount_o,
   output logic              active_o,
   output logic              hsync_o,
   output logic              vsync_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
   localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
   localparam logic [HCNT_W-1:0] HS_BEG = HCNT_W'(H_ACTIVE + H_FP);
   localparam logic [HCNT_W-1:0] HS_END = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
   localparam logic [VCNT_W-1:0] V_ACT  = VCNT_W'(V_ACTIVE);
   localparam logic [VCNT_W-1:0] VS_BEG = VCNT_W'(V_ACTIVE + V_FP);
   localparam logic [VCNT_W-1:0] VS_END = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [HCNT_W-1:0] hcount_q, hcount_d;
   logic [VCNT_W-1:0] vcount_q, vcount_d;

   always_comb begin
      hcount_d = hcount_q + 1'b1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST) begin
         hcount_d = '0;
         vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   assign hcount_o = hcount_q;
   assign vcount_o = vcount_q;
   assign active_o = (hcount_q < H_ACT) && (vcount_q < V_ACT);
   assign hsync_o  = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
   assign vsync_o  = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));

endmodule

// File: rtl/vga_frame_fetch.sv
// 640x480 cell fetch: raster timing, cell-RAM read addressing, blanking-only
// write arbitration and a 2-stage output pipeline aligned to RAM read latency.
module vga_frame_fetch
   import vga_pkg::*;
#(
   parameter int H_ACTIVE      = H_ACTIVE_DFLT,
   parameter int H_FP          = H_FP_DFLT,
   parameter int H_SYNC        = H_SYNC_DFLT,
   parameter int H_BP          = H_BP_DFLT,
   parameter int V_ACTIVE      = V_ACTIVE_DFLT,
   parameter int V_FP          = V_FP_DFLT,
   parameter int V_SYNC        = V_SYNC_DFLT,
   parameter int V_BP          = V_BP_DFLT,
   parameter int SCALE_SHIFT   = SCALE_SHIFT_DFLT,
   parameter int DATA_WIDTH    = PIX_W,
   parameter int ADDRESS_WIDTH = ADDR_W_DFLT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_req,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     wr_ack,
   output logic                     ram_wEn,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_dataIn,
   input  logic [DATA_WIDTH-1:0]    ram_dataOut,
   output logic                     hsync,
   output logic                     vsync,
   output logic                     active,
   output logic [DATA_WIDTH-1:0]    pixel
);

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HCNT_W    = $clog2(H_TOTAL);
   localparam int VCNT_W    = $clog2(V_TOTAL);
   localparam int CELLS_X   = H_ACTIVE >> SCALE_SHIFT;
   localparam int CELLS_Y   = V_ACTIVE >> SCALE_SHIFT;
   localparam int NUM_CELLS = CELLS_X * CELLS_Y;

   localparam logic [31:0] CELLS_X_U   = CELLS_X;
   localparam logic [31:0] NUM_CELLS_U = NUM_CELLS;

   logic [HCNT_W-1:0] hcount;
   logic [VCNT_W-1:0] vcount;
   vid_ctl_t          ctl0, ctl1_q, ctl2_q;
   logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
   logic [31:0]       row_w, col_w;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic              grant, wr_in_range;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .HCNT_W   (HCNT_W),
      .VCNT_W   (VCNT_W)
   ) u_timing (
      .clk      (clk),
      .reset    (reset),
      .hcount_o (hcount),
      .vcount_o (vcount),
      .active_o (ctl0.active),
      .hsync_o  (ctl0.hsync),
      .vsync_o  (ctl0.vsync)
   );

   // Blanking positions also produce an address; it is harmless because the
   // resulting read data is masked by the delayed active flag.
   assign row_w   = 32'(vcount >> SCALE_SHIFT);
   assign col_w   = 32'(hcount >> SCALE_SHIFT);
   assign rd_addr = ADDRESS_WIDTH'(row_w * CELLS_X_U + col_w);

   // Writes only ever steal the port while the fetch position is blanked.
   assign wr_in_range = (32'(wr_addr) < NUM_CELLS_U);
   assign grant       = wr_req && !ctl0.active;
   assign wr_ack      = grant;
   assign ram_wEn     = grant && wr_in_range;
   assign ram_addr    = ram_wEn ? wr_addr : rd_addr;
   assign ram_dataIn  = wr_data;

   assign pixel_d = ctl1_q.active ? ram_dataOut : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctl1_q  <= CTL_IDLE;
         ctl2_q  <= CTL_IDLE;
         pixel_q <= '0;
      end else begin
         ctl1_q  <= ctl0;
         ctl2_q  <= ctl1_q;
         pixel_q <= pixel_d;
      end
   end

   assign hsync  = ctl2_q.hsync;
   assign vsync  = ctl2_q.vsync;
   assign active = ctl2_q.active;
   assign pixel  = pixel_q;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Bench for vga_frame_fetch: directed vectors on full 640x480 timing plus a
// randomized write/readout run on a shrunk raster against a behavioural model.
module tb_vga_frame_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h @%0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- full-size instance (A) ----------------
   logic        rst_a, req_a;
   logic [10:0] waddr_a;
   logic [7:0]  wdata_a;
   logic        ack_a, wen_a, hs_a, vs_a, act_a;
   logic [10:0] addr_a;
   logic [7:0]  din_a, dout_a, pix_a;
   logic [7:0]  mem_a [0:2047];
   logic        clr_a, pre_we_a;
   logic [10:0] pre_addr_a;
   logic [7:0]  pre_data_a;

   vga_frame_fetch dut_a (
      .clk (clk), .reset (rst_a), .wr_req (req_a), .wr_addr (waddr_a), .wr_data (wdata_a),
      .wr_ack (ack_a), .ram_wEn (wen_a), .ram_addr (addr_a), .ram_dataIn (din_a),
      .ram_dataOut (dout_a), .hsync (hs_a), .vsync (vs_a), .active (act_a), .pixel (pix_a)
   );

   always @(posedge clk) begin
      if (clr_a) begin
         for (int i = 0; i < 2048; i++) mem_a[i] <= 8'h00;
      end else if (pre_we_a) mem_a[pre_addr_a] <= pre_data_a;
      else if (wen_a) mem_a[addr_a] <= din_a;
      else dout_a <= mem_a[addr_a];
   end

   // ---------------- shrunk instance (B): 80x55 total, 4x3 cells ----------------
   localparam int BH_A = 64, BH_T = 80, BV_A = 48, BV_T = 55, BNC = 12;
   logic        rst_b, req_b;
   logic [10:0] waddr_b;
   logic [7:0]  wdata_b;
   logic        ack_b, wen_b, hs_b, vs_b, act_b;
   logic [10:0] addr_b;
   logic [7:0]  din_b, dout_b, pix_b;
   logic [7:0]  mem_b [0:2047];
   logic        clr_b, pre_we_b;
   logic [10:0] pre_addr_b;
   logic [7:0]  pre_data_b;

   vga_frame_fetch #(
      .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
      .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3)
   ) dut_b (
      .clk (clk), .reset (rst_b), .wr_req (req_b), .wr_addr (waddr_b), .wr_data (wdata_b),
      .wr_ack (ack_b), .ram_wEn (wen_b), .ram_addr (addr_b), .ram_dataIn (din_b),
      .ram_dataOut (dout_b), .hsync (hs_b), .vsync (vs_b), .active (act_b), .pixel (pix_b)
   );

   always @(posedge clk) begin
      if (clr_b) begin
         for (int i = 0; i < 2048; i++) mem_b[i] <= 8'h00;
      end else if (pre_we_b) mem_b[pre_addr_b] <= pre_data_b;
      else if (wen_b) mem_b[addr_b] <= din_b;
      else dout_b <= mem_b[addr_b];
   end

   typedef struct {
      int   cyc;
      int   addr;
      bit   hs;
      bit   vs;
      bit   act;
      int   pix;
   } vec_t;

   typedef struct {
      bit act;
      bit hs;
      bit vs;
      int pix;
   } ctl_t;

   vec_t tbl [20];
   int   model_mem [14];
   ctl_t exp_q [$];

   task automatic step_a(inout int pa);
      @(posedge clk); #2; pa++;
   endtask

   initial begin
      int pa, hs_low, early, ackpos;
      int pb, h, v, rd, nfalls, last_fall, fall_at;
      bit act0, grant, wen, last_ack, vs_prev;
      ctl_t cur, ex;

      tbl[0]  = '{0,     0,  1, 1, 0, 'h00};
      tbl[1]  = '{1,     0,  1, 1, 0, 'h00};
      tbl[2]  = '{2,     0,  1, 1, 1, 'h3C};
      tbl[3]  = '{15,    0,  1, 1, 1, 'h3C};
      tbl[4]  = '{16,    1,  1, 1, 1, 'h3C};
      tbl[5]  = '{17,    1,  1, 1, 1, 'h3C};
      tbl[6]  = '{18,    1,  1, 1, 1, 'h05};
      tbl[7]  = '{639,   39, 1, 1, 1, 'h9E};
      tbl[8]  = '{641,   40, 1, 1, 1, 'h9E};
      tbl[9]  = '{642,   40, 1, 1, 0, 'h00};
      tbl[10] = '{657,   41, 1, 1, 0, 'h00};
      tbl[11] = '{658,   41, 0, 1, 0, 'h00};
      tbl[12] = '{753,   47, 0, 1, 0, 'h00};
      tbl[13] = '{754,   47, 1, 1, 0, 'h00};
      tbl[14] = '{799,   49, 1, 1, 0, 'h00};
      tbl[15] = '{801,   0,  1, 1, 0, 'h00};
      tbl[16] = '{802,   0,  1, 1, 1, 'h3C};
      tbl[17] = '{12800, 40, 1, 1, 0, 'h00};
      tbl[18] = '{12802, 40, 1, 1, 1, 'h77};
      tbl[19] = '{12818, 41, 1, 1, 1, 'h12};

      rst_a = 1'b1; rst_b = 1'b1;
      req_a = 1'b0; waddr_a = '0; wdata_a = '0;
      req_b = 1'b0; waddr_b = '0; wdata_b = '0;
      clr_a = 1'b1; clr_b = 1'b1; pre_we_a = 1'b0; pre_we_b = 1'b0;
      pre_addr_a = '0; pre_data_a = '0; pre_addr_b = '0; pre_data_b = '0;
      @(posedge clk); #2;
      clr_a = 1'b0; clr_b = 1'b0;

      // RAM preloads (both instances held in reset meanwhile)
      for (int i = 0; i < 6; i++) begin
         int ad [6];
         int dt [6];
         ad = '{0, 1, 39, 40, 41, 5};
         dt = '{'h3C, 'h05, 'h9E, 'h77, 'h12, 'h33};
         pre_we_a = 1'b1; pre_addr_a = 11'(ad[i]); pre_data_a = 8'(dt[i]);
         @(posedge clk); #2;
      end
      pre_we_a = 1'b0;
      for (int i = 0; i < 14; i++) model_mem[i] = 0;
      for (int i = 0; i < BNC; i++) begin
         model_mem[i] = int'($urandom_range(1, 255));
         pre_we_b = 1'b1; pre_addr_b = 11'(i); pre_data_b = 8'(model_mem[i]);
         @(posedge clk); #2;
      end
      pre_we_b = 1'b0;

      // Reset state, with a request pending that must not be granted
      req_a = 1'b1; waddr_a = 11'd7; wdata_a = 8'hEE;
      #1;
      chk("rst_hsync", hs_a, 1);
      chk("rst_vsync", vs_a, 1);
      chk("rst_active", act_a, 0);
      chk("rst_pixel", pix_a, 0);
      chk("rst_ack", ack_a, 0);
      chk("rst_wen", wen_a, 0);
      req_a = 1'b0;

      // First-line fetch and sync vectors
      @(posedge clk); #2;
      rst_a = 1'b0; pa = 0; hs_low = 0;
      #1;
      for (int i = 0; i < 20; i++) begin
         while (pa < tbl[i].cyc) begin
            step_a(pa);
            if (pa >= 2 && pa <= 801 && hs_a == 1'b0) hs_low++;
         end
         chk($sformatf("vec%0d_addr", i), addr_a, tbl[i].addr);
         chk($sformatf("vec%0d_hsync", i), hs_a, tbl[i].hs);
         chk($sformatf("vec%0d_vsync", i), vs_a, tbl[i].vs);
         chk($sformatf("vec%0d_active", i), act_a, tbl[i].act);
         chk($sformatf("vec%0d_pixel", i), pix_a, tbl[i].pix);
      end
      chk("hsync_width", hs_low, 96);

      // Write raised mid-line waits for hcount=640
      while (pa < 17*800 + 100) step_a(pa);
      req_a = 1'b1; waddr_a = 11'd3; wdata_a = 8'hAA;
      #1;
      early = 0; ackpos = -1;
      for (int k = 0; k < 1500; k++) begin
         if (ack_a) begin ackpos = pa; break; end
         if (wen_a) early++;
         step_a(pa);
      end
      chk("defer_ack_pos", ackpos, 17*800 + 640);
      chk("defer_early_wen", early, 0);
      chk("defer_wen", wen_a, 1);
      chk("defer_addr", addr_a, 3);
      chk("defer_data", din_a, 'hAA);
      step_a(pa);
      req_a = 1'b0;
      #1;
      chk("defer_ack_drop", ack_a, 0);
      chk("defer_mem", mem_a[3], 'hAA);

      // Reset landing on a grant cycle kills the write at once
      while (pa < 17*800 + 700) step_a(pa);
      req_a = 1'b1; waddr_a = 11'd5; wdata_a = 8'h5A;
      #1;
      chk("rw_grant", ack_a, 1);
      rst_a = 1'b1;
      #1;
      chk("rw_wen", wen_a, 0);
      chk("rw_ack", ack_a, 0);
      chk("rw_hsync", hs_a, 1);
      chk("rw_active", act_a, 0);
      chk("rw_pixel", pix_a, 0);
      @(posedge clk); #2;
      chk("rw_mem_kept", mem_a[5], 'h33);
      rst_a = 1'b0; pa = 0;
      #1;
      ackpos = -1;
      for (int k = 0; k < 1500; k++) begin
         if (ack_a) begin ackpos = pa; break; end
         step_a(pa);
      end
      chk("rw_regrant_pos", ackpos, 640);
      chk("rw_regrant_wen", wen_a, 1);
      step_a(pa);
      req_a = 1'b0;
      #1;
      chk("rw_mem_new", mem_a[5], 'h5A);

      // Randomized run on the shrunk raster against the behavioural model
      exp_q.delete();
      exp_q.push_back('{0, 1, 1, 0});
      exp_q.push_back('{0, 1, 1, 0});
      last_ack = 1'b0; vs_prev = 1'b1; nfalls = 0; last_fall = -1; fall_at = -1;
      @(posedge clk); #2;
      rst_b = 1'b0; pb = 0;
      for (int n = 0; n < 3*BH_T*BV_T + 200; n++) begin
         if (n > 0) begin
            @(posedge clk); #2; pb++;
         end
         if (!req_b || last_ack) begin
            req_b   = ($urandom_range(0, 3) == 0);
            waddr_b = 11'($urandom_range(0, 13));
            wdata_b = 8'($urandom);
         end
         #1;
         h     = pb % BH_T;
         v     = (pb / BH_T) % BV_T;
         act0  = (h < BH_A) && (v < BV_A);
         rd    = (v / 16) * 4 + (h / 16);
         grant = req_b && !act0;
         wen   = grant && (int'(waddr_b) < BNC);
         chk("sm_ack", ack_b, grant);
         chk("sm_wen", wen_b, wen);
         if (wen) begin
            chk("sm_waddr", addr_b, waddr_b);
            chk("sm_wdata", din_b, wdata_b);
         end else if (!grant) begin
            chk("sm_raddr", addr_b, rd);
         end
         ex = exp_q.pop_front();
         chk("sm_pixel", pix_b, ex.pix);
         chk("sm_active", act_b, ex.act);
         chk("sm_hsync", hs_b, ex.hs);
         chk("sm_vsync", vs_b, ex.vs);
         cur.act = act0;
         cur.hs  = !(h >= 68 && h < 76);
         cur.vs  = !(v >= 50 && v < 52);
         cur.pix = act0 ? model_mem[rd] : 0;
         exp_q.push_back(cur);
         if (wen) model_mem[waddr_b] = int'(wdata_b);
         last_ack = grant;
         if (vs_prev && !vs_b) begin
            if (last_fall >= 0) chk("frame_period", pb - last_fall, BH_T*BV_T);
            last_fall = pb; fall_at = pb; nfalls++;
         end
         if (!vs_prev && vs_b) chk("vsync_width", pb - fall_at, 2*BH_T);
         vs_prev = vs_b;
      end
      req_b = 1'b0;
      chk("vsync_falls", nfalls, 3);
      @(posedge clk); #2;
      for (int i = 0; i < 14; i++) chk($sformatf("sm_mem%0d", i), mem_b[i], model_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
